// File: rtl/gs_uart_pkg.sv
// Shared opcode and reply constants plus the bridge FSM state encoding for the UART bus bridge.
package gs_uart_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h57;
  localparam logic [7:0] OP_READ      = 8'h52;
  localparam logic [7:0] OP_INC_READ  = 8'h4E;
  localparam logic [7:0] OP_INC_WRITE = 8'h4D;

  localparam logic [7:0] REPLY_ACK = 8'h2B;
  localparam logic [7:0] REPLY_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_ACC,
    ST_BUS_WAIT,
    ST_RESP
  } bridge_state_t;

  // States in which the parser is waiting for the next command byte.
  function automatic logic is_byte_state(input bridge_state_t s);
    return (s == ST_ADDR_H) || (s == ST_ADDR_L) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/gs_uart_tx_sender.sv
// One-byte reply holder: accepts a byte on load while ready and strobes uart_tx_en
// on the first cycle the transmitter is not busy.
module gs_uart_tx_sender (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       ready,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data
);

  logic       full;
  logic [7:0] byte_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full   <= 1'b0;
      byte_q <= 8'h00;
    end else if (load && !full) begin
      full   <= 1'b1;
      byte_q <= load_data;
    end else if (full && !uart_tx_busy) begin
      full <= 1'b0;
    end
  end

  // The strobe is combinational so it fires in the very cycle busy is seen low.
  assign ready        = ~full;
  assign uart_tx_en   = full & ~uart_tx_busy;
  assign uart_tx_data = byte_q;

endmodule

// File: rtl/gs_uart_bus_bridge.sv
// UART-driven bus initiator: parses 'W'/'R' byte commands, performs one bus access, replies.
// Defining GS_UART_BRIDGE_AUTOINC_EN adds 'N'/'M' commands that address last_addr+1.
module gs_uart_bus_bridge
  import gs_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_tx_busy,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di
);

  localparam int unsigned     TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]      LAST_WAIT = 2'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 3 || CLK_HZ == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("gs_uart_bus_bridge: READ_LATENCY must be 1..3, CLK_HZ and TIMEOUT_CYCLES nonzero");
  end

  bridge_state_t   state;
  bridge_state_t   next_state;
  logic [15:0]     addr_q;
  logic [7:0]      data_q;
  logic            is_write_q;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      wait_cnt;
  logic            timed_out;
  logic            rx_is_write;
  logic            reply_load;
  logic [7:0]      reply_byte;
  logic            sender_ready;

`ifdef GS_UART_BRIDGE_AUTOINC_EN
  logic [15:0]     last_addr_q;
`endif

  assign timed_out = (to_cnt == TO_LIMIT);

  always_comb begin
    rx_is_write = (uart_rx_data == OP_WRITE);
`ifdef GS_UART_BRIDGE_AUTOINC_EN
    rx_is_write = rx_is_write | (uart_rx_data == OP_INC_WRITE);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    reply_load = 1'b0;
    reply_byte = REPLY_ERR;
    case (state)
      ST_IDLE: begin
        if (uart_rx_valid) begin
          if (uart_rx_data == OP_WRITE || uart_rx_data == OP_READ) begin
            next_state = ST_ADDR_H;
          end
`ifdef GS_UART_BRIDGE_AUTOINC_EN
          else if (uart_rx_data == OP_INC_READ) begin
            next_state = ST_BUS_REQ;
          end else if (uart_rx_data == OP_INC_WRITE) begin
            next_state = ST_DATA;
          end
`endif
          else begin
            next_state = ST_RESP;
            reply_load = 1'b1;
            reply_byte = REPLY_ERR;
          end
        end
      end
      ST_ADDR_H: begin
        if (uart_rx_valid)  next_state = ST_ADDR_L;
        else if (timed_out) next_state = ST_IDLE;
      end
      ST_ADDR_L: begin
        if (uart_rx_valid)  next_state = is_write_q ? ST_DATA : ST_BUS_REQ;
        else if (timed_out) next_state = ST_IDLE;
      end
      ST_DATA: begin
        if (uart_rx_valid)  next_state = ST_BUS_REQ;
        else if (timed_out) next_state = ST_IDLE;
      end
      ST_BUS_REQ: begin
        if (bus_gnt) next_state = ST_BUS_ACC;
      end
      ST_BUS_ACC: begin
        next_state = ST_BUS_WAIT;
      end
      ST_BUS_WAIT: begin
        // Reads capture bus_di straight into the sender on the READ_LATENCY-th cycle after bus_cs.
        if (is_write_q || wait_cnt == LAST_WAIT) begin
          next_state = ST_RESP;
          reply_load = 1'b1;
          reply_byte = is_write_q ? REPLY_ACK : bus_di;
        end
      end
      ST_RESP: begin
        if (sender_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      is_write_q <= 1'b0;
    end else if (uart_rx_valid) begin
      case (state)
        ST_IDLE: begin
          is_write_q <= rx_is_write;
`ifdef GS_UART_BRIDGE_AUTOINC_EN
          if (uart_rx_data == OP_INC_READ || uart_rx_data == OP_INC_WRITE)
            addr_q <= last_addr_q + 16'd1;
`endif
        end
        ST_ADDR_H: addr_q[15:8] <= uart_rx_data;
        ST_ADDR_L: addr_q[7:0]  <= uart_rx_data;
        ST_DATA:   data_q       <= uart_rx_data;
        default:   ;
      endcase
    end
  end

`ifdef GS_UART_BRIDGE_AUTOINC_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 last_addr_q <= 16'h0000;
    else if (state == ST_BUS_ACC) last_addr_q <= addr_q;
  end
`endif

  // Inter-byte gap counter: zero outside the byte states, saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                            to_cnt <= '0;
    else if (!is_byte_state(next_state) || uart_rx_valid)   to_cnt <= '0;
    else if (!timed_out)                                    to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   wait_cnt <= 2'd0;
    else if (state == ST_BUS_WAIT) wait_cnt <= wait_cnt + 2'd1;
    else                           wait_cnt <= 2'd0;
  end

  assign bus_req  = (state == ST_BUS_REQ) || (state == ST_BUS_ACC) || (state == ST_BUS_WAIT);
  assign bus_cs   = (state == ST_BUS_ACC);
  assign bus_we   = bus_cs & is_write_q;
  assign bus_addr = addr_q;
  assign bus_do   = data_q;

  gs_uart_tx_sender u_sender (
    .clk          (clk),
    .resetn       (resetn),
    .load         (reply_load),
    .load_data    (reply_byte),
    .ready        (sender_ready),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data)
  );

endmodule

// File: tb/tb_gs_uart_bus_bridge.sv
// Scoreboard bench for gs_uart_bus_bridge: random byte commands against a command-level model,
// with behavioural arbiter, memory slave and UART transmitter around the DUT.
`timescale 1ns/1ps
module tb_gs_uart_bus_bridge;

  localparam int unsigned TIMEOUT_CYCLES = 40;
  localparam int unsigned READ_LATENCY   = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_tx_busy;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_cs;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_do;
  logic [7:0]  bus_di = 8'h00;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_txn_t;

  bus_txn_t    exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] last_addr_m = 16'h0000;

  int   checks = 0;
  int   failures = 0;
  int   tx_count = 0;
  bit   req_seen = 1'b0;
  bit   force_busy = 1'b0;
  bit   busy_model = 1'b0;
  int   busy_left = 0;
  int   gnt_delay = 0;
  int   gnt_wait = 0;
  bit   gnt_hold = 1'b0;
  int   rd_left = 0;
  logic [15:0] rd_addr = 16'h0000;

  assign uart_tx_busy = force_busy | busy_model;

  always #5 clk = ~clk;

  gs_uart_bus_bridge #(
    .CLK_HZ         (50000000),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .READ_LATENCY   (READ_LATENCY)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_data  (uart_tx_data),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .bus_cs        (bus_cs),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_do        (bus_do),
    .bus_di        (bus_di)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit isKnown(input logic [7:0] op);
    bit k;
    k = (op == 8'h57) || (op == 8'h52);
`ifdef GS_UART_BRIDGE_AUTOINC_EN
    k = k || (op == 8'h4E) || (op == 8'h4D);
`endif
    return k;
  endfunction

  function automatic int cmdLen(input logic [7:0] op);
    case (op)
      8'h57: return 4;
      8'h52: return 3;
`ifdef GS_UART_BRIDGE_AUTOINC_EN
      8'h4D: return 2;
`endif
      default: return 1;
    endcase
  endfunction

  // Command-level reference: what the bus and the host must see for one complete command.
  task automatic modelCommand(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    logic [15:0] a;
    bus_txn_t t;
    a = {b1, b2};
    case (b0)
      8'h57: begin
        t = '{we: 1'b1, addr: a, data: b3};
        ref_mem[a] = b3; last_addr_m = a;
        exp_bus.push_back(t); exp_tx.push_back(8'h2B);
      end
      8'h52: begin
        t = '{we: 1'b0, addr: a, data: ref_mem[a]};
        last_addr_m = a;
        exp_bus.push_back(t); exp_tx.push_back(ref_mem[a]);
      end
`ifdef GS_UART_BRIDGE_AUTOINC_EN
      8'h4E: begin
        a = last_addr_m + 16'd1;
        t = '{we: 1'b0, addr: a, data: ref_mem[a]};
        last_addr_m = a;
        exp_bus.push_back(t); exp_tx.push_back(ref_mem[a]);
      end
      8'h4D: begin
        a = last_addr_m + 16'd1;
        t = '{we: 1'b1, addr: a, data: b1};
        ref_mem[a] = b1; last_addr_m = a;
        exp_bus.push_back(t); exp_tx.push_back(8'h2B);
      end
`endif
      default: exp_tx.push_back(8'h3F);
    endcase
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input int gap);
    logic [7:0] bytes [4];
    int n;
    modelCommand(b0, b1, b2, b3);
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    n = cmdLen(b0);
    for (int i = 0; i < n; i++) sendByte(bytes[i], gap);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000 && (exp_bus.size() != 0 || exp_tx.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_pending", 32'(exp_bus.size() + exp_tx.size()), 0);
    exp_bus.delete();
    exp_tx.delete();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // Monitor, memory slave and arbiter, all sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus_req) req_seen = 1'b1;
      if (bus_cs) begin
        checkOutput("bus_access_expected", 32'(exp_bus.size() != 0), 1);
        if (exp_bus.size() != 0) begin
          bus_txn_t e;
          e = exp_bus.pop_front();
          checkOutput("bus_access", 32'({bus_we, bus_addr, bus_we ? bus_do : 8'h00}),
                      32'({e.we, e.addr, e.we ? e.data : 8'h00}));
        end
      end
      if (uart_tx_en) begin
        tx_count++;
        checkOutput("tx_while_busy", 32'(uart_tx_busy), 0);
        checkOutput("tx_expected", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) checkOutput("tx_data", 32'(uart_tx_data), 32'(exp_tx.pop_front()));
        busy_left = $urandom_range(0, 6);
      end
    end
    if (bus_cs) begin
      rd_addr = bus_addr;
      if (bus_we) mem[bus_addr] = bus_do;
      rd_left = bus_we ? 0 : READ_LATENCY;
      bus_di  = ~mem[bus_addr];
    end else if (rd_left > 0) begin
      rd_left--;
      bus_di = (rd_left == 0) ? mem[rd_addr] : ~mem[rd_addr];
    end else begin
      bus_di = ~mem[rd_addr];
    end
    if (!bus_req) begin
      bus_gnt  = 1'b0;
      gnt_wait = 0;
    end else if (!bus_gnt) begin
      if (!gnt_hold && gnt_wait >= gnt_delay) bus_gnt = 1'b1;
      else gnt_wait++;
    end
  end

  always @(posedge clk) begin
    #1;
    busy_model = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tx_before;
    int sel;
    logic [7:0] op;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'hBEEF] = 8'h5C;
    ref_mem[16'hBEEF] = 8'h5C;

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'({uart_tx_en, uart_tx_data}), 0);
    checkOutput("reset_bus", 32'({bus_req, bus_cs, bus_we, bus_addr}), 0);
    checkOutput("reset_do", 32'(bus_do), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] directed write 57 12 34 A5, grant after 3 cycles");
    gnt_delay = 3;
    applyStimulus(8'h57, 8'h12, 8'h34, 8'hA5, 0);
    waitDrain();

    $display("[TB] directed read 52 BE EF");
    applyStimulus(8'h52, 8'hBE, 8'hEF, 8'h00, 1);
    waitDrain();

    $display("[TB] unknown command 0x41");
    req_seen = 1'b0;
    applyStimulus(8'h41, 8'h00, 8'h00, 8'h00, 0);
    waitDrain();
    checkOutput("unknown_no_bus_req", 32'(req_seen), 0);
    applyStimulus(8'h52, 8'h00, 8'h00, 8'h00, 0);
    waitDrain();

    $display("[TB] inter-byte timeout");
    req_seen = 1'b0;
    sendByte(8'h57, 0);
    sendByte(8'h12, 0);
    repeat (TIMEOUT_CYCLES + 10) begin @(posedge clk); #1; end
    checkOutput("timeout_no_bus_req", 32'(req_seen), 0);
    applyStimulus(8'h52, 8'h00, 8'h10, 8'h00, 0);
    waitDrain();

    $display("[TB] longest legal inter-byte gap");
    applyStimulus(8'h57, 8'h00, 8'h33, 8'h6D, TIMEOUT_CYCLES);
    waitDrain();
    applyStimulus(8'h52, 8'h00, 8'h33, 8'h00, 2);
    waitDrain();

    $display("[TB] transmitter held busy during reply");
    force_busy = 1'b1;
    tx_before = tx_count;
    applyStimulus(8'h52, 8'h40, 8'h00, 8'h00, 0);
    for (int i = 0; i < 100 && exp_bus.size() != 0; i++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    sendByte(8'h57, 5);
    sendByte(8'h41, 5);
    sendByte(8'h52, 5);
    repeat (180) begin @(posedge clk); #1; end
    checkOutput("no_tx_while_forced_busy", 32'(tx_count - tx_before), 0);
    force_busy = 1'b0;
    waitDrain();
    checkOutput("single_tx_after_busy", 32'(tx_count - tx_before), 1);
    applyStimulus(8'h52, 8'h40, 8'h01, 8'h00, 0);
    waitDrain();

`ifdef GS_UART_BRIDGE_AUTOINC_EN
    $display("[TB] auto-increment wrap");
    applyStimulus(8'h52, 8'hFF, 8'hFF, 8'h00, 0);
    waitDrain();
    applyStimulus(8'h4E, 8'h00, 8'h00, 8'h00, 0);
    waitDrain();
    applyStimulus(8'h4D, 8'h9A, 8'h00, 8'h00, 0);
    waitDrain();
`else
    $display("[TB] auto-increment opcodes rejected");
    applyStimulus(8'h4E, 8'h00, 8'h00, 8'h00, 0);
    waitDrain();
    applyStimulus(8'h4D, 8'h00, 8'h00, 8'h00, 0);
    waitDrain();
`endif

    $display("[TB] randomized commands");
    for (int k = 0; k < 25; k++) begin
      sel = $urandom_range(0, 5);
      a = ($urandom_range(0, 2) == 0) ? (16'h0100 + 16'($urandom_range(0, 3))) : 16'($urandom);
      case (sel)
        0, 1: op = 8'h57;
        2, 3: op = 8'h52;
        4: begin
          op = 8'($urandom);
          while (isKnown(op)) op = 8'($urandom);
        end
        default: begin
`ifdef GS_UART_BRIDGE_AUTOINC_EN
          op = ($urandom_range(0, 1) == 0) ? 8'h4E : 8'h4D;
`else
          op = 8'h52;
`endif
        end
      endcase
      gnt_delay = $urandom_range(0, 4);
      applyStimulus(op, a[15:8], a[7:0], 8'($urandom), $urandom_range(0, 5));
      waitDrain();
    end

    $display("[TB] reset during bus request");
    gnt_hold = 1'b1;
    applyStimulus(8'h52, 8'h00, 8'h20, 8'h00, 0);
    for (int i = 0; i < 100 && !bus_req; i++) begin @(posedge clk); #1; end
    checkOutput("req_before_reset", 32'(bus_req), 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("req_drop_async", 32'({bus_req, bus_cs}), 0);
    exp_bus.delete();
    exp_tx.delete();
    last_addr_m = 16'h0000;
    gnt_hold = 1'b0;
    busy_left = 0;
    repeat (3) begin @(posedge clk); #1; end
    resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    gnt_delay = 1;
    applyStimulus(8'h52, 8'h00, 8'h20, 8'h00, 0);
    waitDrain();
`ifdef GS_UART_BRIDGE_AUTOINC_EN
    applyStimulus(8'h4E, 8'h00, 8'h00, 8'h00, 0);
    waitDrain();
`endif

    repeat (5) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
